addr_fifo_sc: RTL and testbench
===============================

Name: addr_fifo_sc

Overview:
- Single-clock first-in-first-out queue for the AXI4 master address path. Default size is 512 entries × 44 bits (address plus attributes).
- Buffers address beats between the upstream producer and the master issue logic.
- Provides full, empty and programmable almost-full / almost-empty flags.
- Read data is registered: it appears one cycle after an accepted read (no first-word fall-through).

Parameters:
- DATA_W, 44, width of wr_data and rd_data.
- DEPTH_W, 9, log2 of the depth; depth = 2**DEPTH_W = 512.
- ALMOST_FULL_NUM, 60, almost_full is asserted when count >= this value.
- ALMOST_EMPTY_NUM, 4, almost_empty is asserted when count <= this value.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_data  in  DATA_W  write word.
- wr_en  in  1  write request.
- wr_full  out  1  FIFO holds 2**DEPTH_W entries.
- almost_full  out  1  count >= ALMOST_FULL_NUM.
- rd_en  in  1  read request.
- rd_data  out  DATA_W  read word, valid the cycle after an accepted read.
- rd_empty  out  1  FIFO holds 0 entries.
- almost_empty  out  1  count <= ALMOST_EMPTY_NUM.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - write pointer, read pointer and count go to 0; rd_data goes to 0.
  - rd_empty=1, almost_empty=1, wr_full=0, almost_full=0.
  - Stored RAM contents are don't-care.
- Internal state:
  - wr_ptr and rd_ptr are DEPTH_W+1 bits; the MSB is the wrap bit.
  - count is DEPTH_W+1 bits and ranges 0..512.
- Write acceptance:
  - wr_acc = wr_en & !wr_full.
  - On an accepted write, the RAM is written at wr_ptr[DEPTH_W-1:0] and wr_ptr increments modulo 2**(DEPTH_W+1).
  - wr_en while full is silently dropped: no pointer change, no corruption.
- Read acceptance:
  - rd_acc = rd_en & !rd_empty.
  - On an accepted read, rd_data is loaded from RAM[rd_ptr] at the same edge and rd_ptr increments.
  - Latency is 1: the word is visible from the cycle after the edge that accepted it.
  - rd_en while empty is ignored, and rd_data holds its previous value.
- Count update: count += wr_acc − rd_acc.
  - A simultaneous accepted read and write leaves count unchanged.
- Flags:
  - All four flags are registered and computed from the next-state count, so they are exact from the cycle after each edge.
  - rd_empty = (count==0).
  - wr_full = (count==2**DEPTH_W).
  - almost_full = (count >= ALMOST_FULL_NUM).
  - almost_empty = (count <= ALMOST_EMPTY_NUM).
- Boundary conditions:
  - Full with wr_en and rd_en together: only the read is accepted, count goes to 511, and wr_full deasserts next cycle.
  - Empty with wr_en and rd_en together: only the write is accepted, count goes to 1, rd_empty deasserts next cycle.
  - A word written at edge N can be read by a request sampled at edge N+1, giving data at cycle N+2.
  - No same-address read/write hazard can occur, because reads are only accepted when count >= 1.
- Pointer wrap: the low DEPTH_W bits wrap 511→0 and data order is preserved across the wrap.
- Reset mid-operation: all contents are discarded; the next cycle shows an empty FIFO and the old data is never returned.
- RAM: inferable simple dual-port memory, one write port and one registered read port, both on clk.

Decomposition:
- Package addr_fifo_pkg holds:
  - ADDR_FIFO_DATA_W=44
  - ADDR_FIFO_DEPTH_W=9
  - default ALMOST_FULL_NUM=60
  - default ALMOST_EMPTY_NUM=4
- Sub-module addr_fifo_ram (parameterised by DATA_W and DEPTH_W) is a simple dual-port RAM with a registered read.
- The pointer, count and flag logic stays in the addr_fifo_sc top level.

Test Plan:
- Reset, then hold idle → rd_empty=1, almost_empty=1, wr_full=0, almost_full=0, rd_data=0.
- Fill test:
  - Stimulus: 513 consecutive writes with a descending pattern starting at 44'hFFF_FFFF_FFFF; the 513th write is made while full.
  - Response: wr_full=1 after the 512th write; the 513th is dropped; almost_full=1 once count reaches 60 (visible after the 60th write); almost_empty=0 once count reaches 5.
- Drain test:
  - Stimulus: 513 consecutive rd_en.
  - Response: rd_data on the cycle after each read equals 44'hFFF_FFFF_FFFF, 44'hFFF_FFFF_FFFE, … down to 44'hFFF_FFFF_FE00, with no mismatch.
  - After the 512th read, rd_empty=1; the 513th read is ignored and rd_data holds 44'hFFF_FFFF_FE00.
- Simultaneous access:
  - With count=10, assert wr_en and rd_en for 20 cycles → count stays 10, flags are stable, data order is preserved.
  - At full, assert both → only the read is accepted and count=511.
- Wrap test: 300 writes, 300 reads, then 300 writes and 300 reads → every word returns in order across the 511→0 pointer wrap.
- Reset at count=100 → rd_empty=1 next cycle; a subsequent write of 44'h123 reads back 44'h123 with no stale data returned.

Source files
------------

// File: rtl/addr_fifo_pkg.sv
// Shared constants, flag bundle and flag computation for the AXI4 master address FIFO.
// The flag function is the single definition of how occupancy maps onto the four status flags.
package addr_fifo_pkg;

  localparam int ADDR_FIFO_DATA_W           = 44;
  localparam int ADDR_FIFO_DEPTH_W          = 9;
  localparam int ADDR_FIFO_ALMOST_FULL_NUM  = 60;
  localparam int ADDR_FIFO_ALMOST_EMPTY_NUM = 4;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic almost_empty;
    logic empty;
  } fifo_flags_t;

  localparam fifo_flags_t FIFO_FLAGS_RESET = '{
    full:         1'b0,
    almost_full:  1'b0,
    almost_empty: 1'b1,
    empty:        1'b1
  };

  function automatic fifo_flags_t calc_flags(
    input int unsigned count,
    input int unsigned depth,
    input int unsigned af_num,
    input int unsigned ae_num
  );
    fifo_flags_t f;
    f.full         = (count == depth);
    f.almost_full  = (count >= af_num);
    f.almost_empty = (count <= ae_num);
    f.empty        = (count == 0);
    return f;
  endfunction

endpackage

// File: rtl/addr_fifo_ram.sv
// Simple dual-port RAM: one synchronous write port and one registered read port on the same clock.
// Only the read register is reset; the array itself is left uninitialised so it maps onto block RAM.
module addr_fifo_ram #(
  parameter int DATA_W  = 44,
  parameter int DEPTH_W = 9
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [DEPTH_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]  wdata_i,
  input  logic               re_i,
  input  logic [DEPTH_W-1:0] raddr_i,
  output logic [DATA_W-1:0]  rdata_o
);

  logic [DATA_W-1:0] mem_q [2**DEPTH_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Output register holds its value when no read is accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/addr_fifo_sc.sv
// Single-clock FIFO between the address producer and the AXI4 master issue logic.
// Pointers, occupancy count and registered status flags live here; storage is addr_fifo_ram.
module addr_fifo_sc
  import addr_fifo_pkg::*;
#(
  parameter int DATA_W           = ADDR_FIFO_DATA_W,
  parameter int DEPTH_W          = ADDR_FIFO_DEPTH_W,
  parameter int ALMOST_FULL_NUM  = ADDR_FIFO_ALMOST_FULL_NUM,
  parameter int ALMOST_EMPTY_NUM = ADDR_FIFO_ALMOST_EMPTY_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic              wr_full,
  output logic              almost_full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_empty,
  output logic              almost_empty
);

  localparam int unsigned DEPTH = 2**DEPTH_W;
  localparam logic [DEPTH_W:0] ONE = {{DEPTH_W{1'b0}}, 1'b1};

  logic [DEPTH_W:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_W:0] count_q, count_d;
  fifo_flags_t      flags_q, flags_d;
  logic             wr_acc, rd_acc;

  // Acceptance is decided from registered flags, so a full FIFO can still accept a read.
  assign wr_acc = wr_en & ~flags_q.full;
  assign rd_acc = rd_en & ~flags_q.empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + ONE;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  // Flags come from the next-state count so they are exact in the cycle after each edge.
  always_comb begin
    flags_d = calc_flags(32'(count_d), DEPTH, ALMOST_FULL_NUM, ALMOST_EMPTY_NUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= FIFO_FLAGS_RESET;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
    end
  end

  addr_fifo_ram #(
    .DATA_W  (DATA_W),
    .DEPTH_W (DEPTH_W)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wr_acc & ~rst),
    .waddr_i (wr_ptr_q[DEPTH_W-1:0]),
    .wdata_i (wr_data),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q[DEPTH_W-1:0]),
    .rdata_o (rd_data)
  );

  assign wr_full      = flags_q.full;
  assign almost_full  = flags_q.almost_full;
  assign rd_empty     = flags_q.empty;
  assign almost_empty = flags_q.almost_empty;

  // The wrap-bit pointer distance must always equal the tracked occupancy.
  a_ptr_count_consistent: assert property (
    @(posedge clk) disable iff (rst) ((wr_ptr_q - rd_ptr_q) == count_q)
  );

endmodule

// File: tb/tb_addr_fifo_sc.sv
// Directed self-checking bench for addr_fifo_sc: fill, drain, simultaneous access, wrap and mid-run reset.
module tb_addr_fifo_sc;

  localparam int DW = 44;

  logic          clk;
  logic          rst;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          wr_full;
  logic          almost_full;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_empty;
  logic          almost_empty;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] expRd;

  addr_fifo_sc dut (
    .clk          (clk),
    .rst          (rst),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .wr_full      (wr_full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_empty     (rd_empty),
    .almost_empty (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {wr_full, almost_full, almost_empty, rd_empty} for a given occupancy.
  function automatic logic [3:0] expFlags(input int c);
    return {c == 512, c >= 60, c <= 4, c == 0};
  endfunction

  // Drives one clock of stimulus and advances the reference queue.
  task automatic applyStimulus(input logic we, input logic [DW-1:0] wd, input logic re);
    bit wa;
    bit ra;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    wa = we && (q.size() < 512);
    ra = re && (q.size() > 0);
    @(posedge clk);
    #1;
    if (ra) expRd = q.pop_front();
    if (wa) q.push_back(wd);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    expRd = '0;
    repeat (2) begin
      @(posedge clk);
      #1;
      checks++;
      if ({wr_full, almost_full, almost_empty, rd_empty} !== 4'b0011) begin
        errors++;
        $display("[TB] FAIL reset_flags got %b expected 0011", {wr_full, almost_full, almost_empty, rd_empty});
      end
      checks++;
      if (rd_data !== 44'h0) begin
        errors++;
        $display("[TB] FAIL reset_rd_data got %h expected 0", rd_data);
      end
    end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 513; i++) begin
      int k;
      applyStimulus(1'b1, 44'hFFF_FFFF_FFFF - i, 1'b0);
      k = (i + 1 > 512) ? 512 : i + 1;
      checks++;
      if ({wr_full, almost_full, almost_empty, rd_empty} !== expFlags(k)) begin
        errors++;
        $display("[TB] FAIL fill_flags write %0d got %b expected %b", i + 1,
                 {wr_full, almost_full, almost_empty, rd_empty}, expFlags(k));
      end
    end
  endtask

  task automatic test_drain;
    for (int j = 1; j <= 513; j++) begin
      logic [DW-1:0] exp;
      int k;
      applyStimulus(1'b0, '0, 1'b1);
      exp = (j <= 512) ? 44'hFFF_FFFF_FFFF - (j - 1) : 44'hFFF_FFFF_FE00;
      k = (j > 512) ? 0 : 512 - j;
      checks++;
      if (rd_data !== exp) begin
        errors++;
        $display("[TB] FAIL drain_data read %0d got %h expected %h", j, rd_data, exp);
      end
      checks++;
      if ({wr_full, almost_full, almost_empty, rd_empty} !== expFlags(k)) begin
        errors++;
        $display("[TB] FAIL drain_flags read %0d got %b expected %b", j,
                 {wr_full, almost_full, almost_empty, rd_empty}, expFlags(k));
      end
    end
  endtask

  task automatic test_simultaneous;
    // Empty with both requests: only the write lands, rd_data keeps the last word.
    applyStimulus(1'b1, 44'hA00, 1'b1);
    checks++;
    if ({wr_full, almost_full, almost_empty, rd_empty} !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL empty_both_flags got %b expected 0010", {wr_full, almost_full, almost_empty, rd_empty});
    end
    checks++;
    if (rd_data !== 44'hFFF_FFFF_FE00) begin
      errors++;
      $display("[TB] FAIL empty_both_data got %h expected fffffffffe00", rd_data);
    end
    for (int i = 1; i < 10; i++) applyStimulus(1'b1, 44'hA00 + i, 1'b0);
    for (int i = 0; i < 20; i++) begin
      logic [DW-1:0] exp;
      applyStimulus(1'b1, 44'hB00 + i, 1'b1);
      exp = (i < 10) ? 44'hA00 + i : 44'hB00 + (i - 10);
      checks++;
      if (rd_data !== exp) begin
        errors++;
        $display("[TB] FAIL simul_data cycle %0d got %h expected %h", i, rd_data, exp);
      end
      checks++;
      if ({wr_full, almost_full, almost_empty, rd_empty} !== expFlags(10)) begin
        errors++;
        $display("[TB] FAIL simul_flags cycle %0d got %b expected %b", i,
                 {wr_full, almost_full, almost_empty, rd_empty}, expFlags(10));
      end
    end
    for (int i = 0; i < 502; i++) applyStimulus(1'b1, 44'hC000 + i, 1'b0);
    checks++;
    if ({wr_full, almost_full, almost_empty, rd_empty} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL full_flags got %b expected 1100", {wr_full, almost_full, almost_empty, rd_empty});
    end
    // Full with both requests: only the read is accepted.
    applyStimulus(1'b1, 44'hDEAD, 1'b1);
    checks++;
    if (rd_data !== 44'hB0A) begin
      errors++;
      $display("[TB] FAIL full_both_data got %h expected b0a", rd_data);
    end
    checks++;
    if ({wr_full, almost_full, almost_empty, rd_empty} !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL full_both_flags got %b expected 0100", {wr_full, almost_full, almost_empty, rd_empty});
    end
  endtask

  task automatic test_wrap;
    while (q.size() > 0) begin
      logic [DW-1:0] exp;
      exp = q[0];
      applyStimulus(1'b0, '0, 1'b1);
      checks++;
      if (rd_data !== exp) begin
        errors++;
        $display("[TB] FAIL predrain_data got %h expected %h", rd_data, exp);
      end
    end
    checks++;
    if (rd_empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL predrain_empty got %b expected 1", rd_empty);
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 300; i++) applyStimulus(1'b1, 44'h5_0000_0000 + r * 1000 + i, 1'b0);
      for (int i = 0; i < 300; i++) begin
        logic [DW-1:0] exp;
        applyStimulus(1'b0, '0, 1'b1);
        exp = 44'h5_0000_0000 + r * 1000 + i;
        checks++;
        if (rd_data !== exp) begin
          errors++;
          $display("[TB] FAIL wrap_data round %0d word %0d got %h expected %h", r, i, rd_data, exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, 44'h7_0000 + i, 1'b0);
    checks++;
    if ({wr_full, almost_full, almost_empty, rd_empty} !== expFlags(100)) begin
      errors++;
      $display("[TB] FAIL pre_reset_flags got %b expected %b", {wr_full, almost_full, almost_empty, rd_empty}, expFlags(100));
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    expRd = '0;
    checks++;
    if ({wr_full, almost_full, almost_empty, rd_empty} !== 4'b0011 || rd_data !== 44'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset got flags %b data %h expected 0011 and 0",
               {wr_full, almost_full, almost_empty, rd_empty}, rd_data);
    end
    applyStimulus(1'b1, 44'h123, 1'b0);
    checks++;
    if ({wr_full, almost_full, almost_empty, rd_empty} !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL post_reset_write got %b expected 0010", {wr_full, almost_full, almost_empty, rd_empty});
    end
    applyStimulus(1'b0, '0, 1'b1);
    checks++;
    if (rd_data !== 44'h123 || rd_empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_read got %h empty %b expected 123 empty 1", rd_data, rd_empty);
    end
    applyStimulus(1'b0, '0, 1'b1);
    checks++;
    if (rd_data !== 44'h123) begin
      errors++;
      $display("[TB] FAIL empty_read_hold got %h expected 123", rd_data);
    end
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    expRd   = '0;
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
